regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read core regfile.
- Adds configurable width, depth and read-port count, plus a second write port with priority and two-level write-to-read forwarding.
- Adds a per-register busy scoreboard for issue stalls and a post-reset zero-clear sequencer.
- Sits between decode (reads, alloc) and writeback (two retire lanes) in the dual-issue pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth NREG = 2**ADDR_W; register 0 hardwired to zero.
- NUM_RD, 2, number of read ports (1..4); read buses are flattened, port i at bits [i*W +: W].

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset: synchronous, active-high.
- init_done  out  1  high once the clear sequence has finished.
- we0  in  1  write enable, lane 0.
- waddr0  in  ADDR_W  write address, lane 0.
- wdata0  in  DATA_W  write data, lane 0.
- we1  in  1  write enable, lane 1 (younger; wins conflicts).
- waddr1  in  ADDR_W  write address, lane 1.
- wdata1  in  DATA_W  write data, lane 1.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  read addresses.
- rdata  out  NUM_RD*DATA_W  read data (combinational).
- rbusy  out  NUM_RD  per-port "operand not yet available" (combinational).
- alloc_en  in  1  mark destination busy (instruction issued).
- alloc_addr  in  ADDR_W  destination being allocated.
- flush  in  1  clear entire scoreboard (pipeline flush).

Behaviour:
- Reset (rst=1 at clk edge):
  - init_done<=0, all busy bits<=0, clear counter<=1, FSM<=CLEAR.
  - Array contents are not required to reset.
  - While rst=1, all rdata=0 and all rbusy=0.
- FSM CLEAR:
  - Each cycle writes 0 to regs[cnt] and increments cnt.
  - When cnt=NREG-1 is written, go to DONE and set init_done<=1 (cycle NREG-1 after rst falls).
  - During CLEAR: we0/we1/alloc_en/flush are ignored; rdata=0; rbusy=0.
  - rst asserted mid-CLEAR restarts at cnt=1.
- FSM DONE: normal operation; stays there until rst.
- Writes (DONE only):
  - Lane k writes regs[waddrk]<=wdatak when wek=1 and waddrk!=0.
  - Both lanes to the same nonzero address: lane 1 value stored.
  - Address 0 is never written; it reads 0 always.
- Reads (combinational), per port i, evaluated in this priority order:
  1. rst=1, or !init_done, or re[i]=0, or raddr_i=0 -> 0.
  2. we1 && waddr1==raddr_i -> wdata1.
  3. we0 && waddr0==raddr_i -> wdata0.
  4. Otherwise regs[raddr_i].
  - Zero-cycle forwarding: a read in the same cycle as a write sees the new value.
- Scoreboard busy[NREG] (DONE only), next-state per entry a:
  - flush=1 -> 0 for all entries; overrides alloc and writes.
  - Else alloc_en && alloc_addr==a && a!=0 -> 1. Alloc beats a same-cycle write to the same address, since a new producer is issued.
  - Else (we0 && waddr0==a) || (we1 && waddr1==a) -> 0.
  - Else hold.
  - busy[0] is always 0.
- rbusy[i]:
  - Equals busy[raddr_i] && !(write this cycle to raddr_i on either lane).
  - Forced to 0 if re[i]=0, raddr_i=0, rst=1 or !init_done.
  - Same-cycle alloc does not affect rbusy until the next cycle.
- Latency: reads and rbusy have 0 cycles of latency; writes and busy updates are visible from the cycle after the edge, except via forwarding.

Test Plan:
- Clear sequence (ADDR_W=5): pulse rst, release -> init_done rises exactly 31 cycles later; all 32 reads return 0. Pulse rst at cycle 10 of clearing -> a full 31-cycle restart.
- Basic write/read: we0 x5<=0xDEADBEEF; next cycle raddr port0=5 -> 0xDEADBEEF. Write x0<=0x1234 -> x0 still reads 0.
- Dual-write conflict and forwarding: same cycle we0 x7<=0x11, we1 x7<=0x22 -> same-cycle read x7=0x22, next cycle 0x22. we0 alone x9<=0x33 with read x9 same cycle -> 0x33.
- Scoreboard: alloc x3 -> next cycle rbusy=1 for a read of x3. we1 x3<=0x44 -> rbusy=0 that cycle, rdata=0x44. Same cycle alloc x3 plus we0 x3 -> busy stays 1 afterwards.
- Flush: alloc x4, x6, x8 on consecutive cycles, then flush together with alloc x10 -> all rbusy=0 next cycle, including x10.
- NUM_RD=4 with re mask 4'b1010: ports 0 and 2 read 0 with rbusy 0; ports 1 and 3 return correct data for distinct addresses.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with dual write lanes, write-to-read
//            forwarding, busy scoreboard and post-reset zero-clear sequencer.
// Revision : 1.0
// ============================================================================
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_done,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       alloc_en,
    input  logic [ADDR_W-1:0]          alloc_addr,
    input  logic                       flush
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_idx = {ADDR_W{1'b1}};
    localparam logic [0:0]        c_st_clear = 1'b0;
    localparam logic [0:0]        c_st_done  = 1'b1;

    logic [0:0]        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_init_done, w_init_nxt;
    logic [NREG-1:0]   r_busy, w_busy_nxt;
    logic [DATA_W-1:0] r_regs [NREG];
    logic              w_run;

    assign w_run     = (r_state == c_st_done);
    assign init_done = r_init_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_clear;
            r_cnt       <= ADDR_W'(1);
            r_init_done <= 1'b0;
            r_busy      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= w_init_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_init_nxt  = r_init_done;
        case (r_state)
            c_st_clear: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_last_idx) begin
                    w_state_nxt = c_st_done;
                    w_init_nxt  = 1'b1;
                end
            end
            default: begin
                w_init_nxt = 1'b1;
            end
        endcase
    end

    // Entry 0 is never stored; reads of address 0 are forced to zero instead.
    // Lane 1 is written last so it wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run) begin
                r_regs[r_cnt] <= '0;
            end else begin
                if (we0 && (waddr0 != '0)) r_regs[waddr0] <= wdata0;
                if (we1 && (waddr1 != '0)) r_regs[waddr1] <= wdata1;
            end
        end
    end

    assign w_busy_nxt[0] = 1'b0;

    // Alloc outranks a same-cycle write: the new producer owns the register.
    for (genvar a = 1; a < NREG; a++) begin : g_busy
        localparam logic [ADDR_W-1:0] c_a = ADDR_W'(a);
        logic w_alloc_hit, w_wr_hit;
        assign w_alloc_hit   = alloc_en && (alloc_addr == c_a);
        assign w_wr_hit      = (we0 && (waddr0 == c_a)) || (we1 && (waddr1 == c_a));
        assign w_busy_nxt[a] = !w_run      ? r_busy[a] :
                               flush       ? 1'b0      :
                               w_alloc_hit ? 1'b1      :
                               w_wr_hit    ? 1'b0      : r_busy[a];
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_gate, w_hit0, w_hit1;
        assign w_ra   = raddr[i*ADDR_W +: ADDR_W];
        assign w_gate = rst || !r_init_done || !re[i] || (w_ra == '0);
        assign w_hit1 = we1 && (waddr1 == w_ra);
        assign w_hit0 = we0 && (waddr0 == w_ra);
        assign rdata[i*DATA_W +: DATA_W] = w_gate ? '0     :
                                           w_hit1 ? wdata1 :
                                           w_hit0 ? wdata0 : r_regs[w_ra];
        assign rbusy[i] = !w_gate && r_busy[w_ra] && !w_hit0 && !w_hit1;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Self-checking bench for regfile_mp with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_regfile_mp;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 4;
    localparam int NREG = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             init_done;
    logic             we0, we1, alloc_en, flush;
    logic [AW-1:0]    waddr0, waddr1, alloc_addr;
    logic [DW-1:0]    wdata0, wdata1;
    logic [NR-1:0]    re, rbusy;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] m_regs [NREG];
    bit            m_busy [NREG];
    bit            m_ready = 1'b0;
    int            m_cnt   = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
    );

    always #5 clk = ~clk;

    // Architectural state update for one rising edge.
    function automatic void model_edge();
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            for (int a = 0; a < NREG; a++) m_busy[a] = 1'b0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == NREG - 1) begin
                m_ready = 1'b1;
                for (int a = 0; a < NREG; a++) m_regs[a] = '0;
            end
        end else begin
            if (flush) begin
                for (int a = 0; a < NREG; a++) m_busy[a] = 1'b0;
            end else begin
                if (we0) m_busy[waddr0] = 1'b0;
                if (we1) m_busy[waddr1] = 1'b0;
                if (alloc_en) m_busy[alloc_addr] = 1'b1;
                m_busy[0] = 1'b0;
            end
            if (we0 && waddr0 != 0) m_regs[waddr0] = wdata0;
            if (we1 && waddr1 != 0) m_regs[waddr1] = wdata1;
        end
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int i);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        if (rst || !m_ready || !re[i] || a == 0) return '0;
        if (we1 && waddr1 == a) return wdata1;
        if (we0 && waddr0 == a) return wdata0;
        return m_regs[a];
    endfunction

    function automatic logic exp_rb(input int i);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        if (rst || !m_ready || !re[i] || a == 0) return 1'b0;
        if ((we0 && waddr0 == a) || (we1 && waddr1 == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [DW-1:0] rd(input int i);
        return rdata[i*DW +: DW];
    endfunction

    task automatic set_ra(input int i, input logic [AW-1:0] a);
        raddr[i*AW +: AW] = a;
    endtask

    task automatic drive_idle();
        we0 = 0; waddr0 = '0; wdata0 = '0;
        we1 = 0; waddr1 = '0; wdata1 = '0;
        re = '0; raddr = '0; alloc_en = 0; alloc_addr = '0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int n;
        drive_idle(); rst = 1; tick();
        re = '1;
        for (int i = 0; i < NR; i++) set_ra(i, AW'(i + 1));
        #1;
        vectors++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b expected 0", init_done); end
        for (int i = 0; i < NR; i++) begin
            vectors++;
            if (rd(i) !== '0 || rbusy[i] !== 1'b0) begin
                errors++; $display("FAIL reset_read port%0d got %h/%b expected 0/0", i, rd(i), rbusy[i]);
            end
        end
        rst = 0;
        we0 = 1; waddr0 = 5'd5; wdata0 = '1; alloc_en = 1; alloc_addr = 5'd5;
        set_ra(0, 5'd5);
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            #1;
            vectors++;
            if (rd(0) !== '0 || rbusy[0] !== 1'b0) begin
                errors++; $display("FAIL clear_read x5 got %h/%b expected 0/0", rd(0), rbusy[0]);
            end
            tick(); n++;
        end
        drive_idle();
        vectors++;
        if (n != 31) begin errors++; $display("FAIL clear_len got %0d cycles expected 31", n); end
        for (int b = 0; b < NREG / NR; b++) begin
            re = '1;
            for (int i = 0; i < NR; i++) set_ra(i, AW'(b * NR + i));
            #1;
            for (int i = 0; i < NR; i++) begin
                vectors++;
                if (rd(i) !== '0 || rbusy[i] !== 1'b0) begin
                    errors++; $display("FAIL cleared_x%0d got %h/%b expected 0/0", b * NR + i, rd(i), rbusy[i]);
                end
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_clear_restart();
        int n;
        drive_idle(); rst = 1; tick(); rst = 0;
        repeat (10) tick();
        rst = 1; tick(); rst = 0;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin tick(); n++; end
        vectors++;
        if (n != 31) begin errors++; $display("FAIL restart_len got %0d cycles expected 31", n); end
    endtask

    task automatic test_basic();
        drive_idle(); we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; tick();
        drive_idle(); re = 4'b0001; set_ra(0, 5'd5); #1;
        vectors++;
        if (rd(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_x5 got %h expected deadbeef", rd(0)); end
        we0 = 1; waddr0 = 5'd0; wdata0 = 32'h1234; set_ra(0, 5'd0); #1;
        vectors++;
        if (rd(0) !== '0) begin errors++; $display("FAIL x0_fwd got %h expected 0", rd(0)); end
        tick();
        drive_idle(); re = 4'b0001; set_ra(0, 5'd0); #1;
        vectors++;
        if (rd(0) !== '0) begin errors++; $display("FAIL x0_after got %h expected 0", rd(0)); end
        drive_idle();
    endtask

    task automatic test_dual_write();
        drive_idle();
        we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22;
        re = 4'b0011; set_ra(0, 5'd7); set_ra(1, 5'd7); #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rd(i) !== 32'h22) begin errors++; $display("FAIL dual_fwd port%0d got %h expected 22", i, rd(i)); end
        end
        tick();
        drive_idle(); re = 4'b0001; set_ra(0, 5'd7); #1;
        vectors++;
        if (rd(0) !== 32'h22) begin errors++; $display("FAIL dual_stored got %h expected 22", rd(0)); end
        we0 = 1; waddr0 = 5'd9; wdata0 = 32'h33; set_ra(0, 5'd9); #1;
        vectors++;
        if (rd(0) !== 32'h33) begin errors++; $display("FAIL lane0_fwd got %h expected 33", rd(0)); end
        tick();
        drive_idle();
    endtask

    task automatic test_scoreboard();
        drive_idle(); alloc_en = 1; alloc_addr = 5'd12; re = 4'b0001; set_ra(0, 5'd12); #1;
        vectors++;
        if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL alloc_same_cycle got %b expected 0", rbusy[0]); end
        tick();
        drive_idle(); re = 4'b0001; set_ra(0, 5'd12); #1;
        vectors++;
        if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL alloc_x12 got %b expected 1", rbusy[0]); end
        drive_idle(); alloc_en = 1; alloc_addr = 5'd3; tick();
        drive_idle(); re = 4'b0001; set_ra(0, 5'd3); #1;
        vectors++;
        if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL busy_x3 got %b expected 1", rbusy[0]); end
        we1 = 1; waddr1 = 5'd3; wdata1 = 32'h44; #1;
        vectors++;
        if (rbusy[0] !== 1'b0 || rd(0) !== 32'h44) begin
            errors++; $display("FAIL wb_x3 got %b/%h expected 0/44", rbusy[0], rd(0));
        end
        tick();
        drive_idle(); re = 4'b0001; set_ra(0, 5'd3); #1;
        vectors++;
        if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL cleared_x3 got %b expected 0", rbusy[0]); end
        alloc_en = 1; alloc_addr = 5'd3; we0 = 1; waddr0 = 5'd3; wdata0 = 32'h55; tick();
        drive_idle(); re = 4'b0001; set_ra(0, 5'd3); #1;
        vectors++;
        if (rbusy[0] !== 1'b1 || rd(0) !== 32'h55) begin
            errors++; $display("FAIL alloc_beats_wr got %b/%h expected 1/55", rbusy[0], rd(0));
        end
        drive_idle();
    endtask

    task automatic test_flush();
        drive_idle(); alloc_en = 1; alloc_addr = 5'd4; tick();
        alloc_addr = 5'd6; tick();
        alloc_addr = 5'd8; tick();
        drive_idle(); flush = 1; alloc_en = 1; alloc_addr = 5'd10; re = '1;
        set_ra(0, 5'd4); set_ra(1, 5'd6); set_ra(2, 5'd8); set_ra(3, 5'd10); #1;
        vectors++;
        if (rbusy !== 4'b0111) begin errors++; $display("FAIL pre_flush got %b expected 0111", rbusy); end
        tick();
        flush = 0; alloc_en = 0; #1;
        vectors++;
        if (rbusy !== 4'b0000) begin errors++; $display("FAIL post_flush got %b expected 0000", rbusy); end
        drive_idle();
    endtask

    task automatic test_mask();
        drive_idle();
        we0 = 1; waddr0 = 5'd20; wdata0 = 32'hA0A0_0020;
        we1 = 1; waddr1 = 5'd21; wdata1 = 32'hA1A1_0021; tick();
        waddr0 = 5'd22; wdata0 = 32'hA2A2_0022;
        waddr1 = 5'd23; wdata1 = 32'hA3A3_0023; tick();
        drive_idle(); alloc_en = 1; alloc_addr = 5'd22; tick();
        drive_idle(); re = 4'b1010;
        set_ra(0, 5'd20); set_ra(1, 5'd21); set_ra(2, 5'd22); set_ra(3, 5'd23); #1;
        vectors++;
        if (rd(0) !== '0 || rd(2) !== '0 || rbusy !== 4'b0000) begin
            errors++; $display("FAIL mask_off got %h %h %b expected 0 0 0000", rd(0), rd(2), rbusy);
        end
        vectors++;
        if (rd(1) !== 32'hA1A1_0021 || rd(3) !== 32'hA3A3_0023) begin
            errors++; $display("FAIL mask_on got %h %h expected a1a10021 a3a30023", rd(1), rd(3));
        end
        re = 4'b1111; #1;
        vectors++;
        if (rbusy !== 4'b0100) begin errors++; $display("FAIL mask_busy got %b expected 0100", rbusy); end
        drive_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we0 = ($urandom_range(0, 1) == 1);
            we1 = ($urandom_range(0, 2) == 0);
            waddr0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            waddr1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            wdata0 = $urandom; wdata1 = $urandom;
            alloc_en = ($urandom_range(0, 2) == 0);
            alloc_addr = AW'($urandom_range(0, 7));
            flush = ($urandom_range(0, 19) == 0);
            re = NR'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) set_ra(i, AW'($urandom_range(0, 8)));
            #1;
            for (int i = 0; i < NR; i++) begin
                vectors++;
                if (rd(i) !== exp_rd(i) || rbusy[i] !== exp_rb(i)) begin
                    errors++;
                    $display("FAIL rand c%0d port%0d got %h/%b expected %h/%b", c, i, rd(i), rbusy[i], exp_rd(i), exp_rb(i));
                end
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst = 1;
        test_reset();
        test_clear_restart();
        test_basic();
        test_dual_write();
        test_scoreboard();
        test_flush();
        test_mask();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
